multi_cycle_controller: RTL and testbench

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

---
 rtl/multi_cycle_controller_pkg.sv | 57 +++++
 rtl/mc_op_decode.sv | 43 ++++
 rtl/multi_cycle_controller.sv | 188 ++++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_controller_pkg.sv
// Shared types for the multi-cycle controller: FSM states, opcodes, datapath select codes.
// No logic beyond a state classification helper; no latency or flow control.
package multi_cycle_controller_pkg;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEMADR,
    ST_MEMREAD,
    ST_MEMWB,
    ST_MEMWRITE,
    ST_EXECR,
    ST_EXECI,
    ST_ALUWB,
    ST_BEQ,
    ST_JAL,
    ST_LUI,
    ST_HALT
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LUI   = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // States that hold mem_req high and are therefore watched by the watchdog.
  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEMREAD) || (s == ST_MEMWRITE);
  endfunction

endpackage

// File: rtl/mc_op_decode.sv
// Opcode classifier: DECODE successor state, store/illegal flags and immediate format.
// Purely combinational (zero latency); no flow control.
module mc_op_decode
  import multi_cycle_controller_pkg::*;
(
  input  logic [6:0] op,
  output state_t     decode_next,
  output logic       is_store,
  output logic       op_illegal,
  output logic [2:0] imm_src
);

  always_comb begin
    decode_next = ST_HALT;
    is_store    = 1'b0;
    op_illegal  = 1'b0;
    case (op)
      OP_LOAD:  decode_next = ST_MEMADR;
      OP_STORE: begin
        decode_next = ST_MEMADR;
        is_store    = 1'b1;
      end
      OP_RTYPE: decode_next = ST_EXECR;
      OP_ITYPE: decode_next = ST_EXECI;
      OP_BEQ:   decode_next = ST_BEQ;
      OP_JAL:   decode_next = ST_JAL;
      OP_LUI:   decode_next = ST_LUI;
      default:  op_illegal  = 1'b1;
    endcase
  end

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_JAL:   imm_src = IMM_J;
      OP_STORE: imm_src = IMM_S;
      OP_BEQ:   imm_src = IMM_B;
      OP_LUI:   imm_src = IMM_U;
      default:  imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle RISC-V style control FSM with memory watchdog; outputs decoded from current state.
// Memory backpressure via mem_ready: request states stall until it is seen, or HALT on watchdog expiry.
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_req,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       branch,
  output logic       instr_retired,
  output logic       illegal,
  output logic       bus_err,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src
);

  state_t      state_q, state_d;
  state_t      dec_next;
  logic        dec_store, dec_illegal;
  logic [15:0] wd_cnt_q;
  logic        wait_mem, wd_expire, set_illegal, pc_update;

  mc_op_decode u_op_decode (
    .op          (op),
    .decode_next (dec_next),
    .is_store    (dec_store),
    .op_illegal  (dec_illegal),
    .imm_src     (imm_src)
  );

  assign wait_mem = is_mem_state(state_q) && !mem_ready;

  // Expire on the wait cycle that brings the count up to MEM_TIMEOUT; a ready in that cycle wins.
  assign wd_expire = (MEM_TIMEOUT != 0) && wait_mem &&
                     ((32'(wd_cnt_q) + 32'd1) == MEM_TIMEOUT);

  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    case (state_q)
      ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        state_d     = dec_next;
        set_illegal = dec_illegal;
      end
      ST_MEMADR:   state_d = dec_store ? ST_MEMWRITE : ST_MEMREAD;
      ST_MEMREAD:  if (mem_ready) state_d = ST_MEMWB;
      ST_MEMWB:    state_d = ST_FETCH;
      ST_MEMWRITE: if (mem_ready) state_d = ST_FETCH;
      ST_EXECR:    state_d = ST_ALUWB;
      ST_EXECI:    state_d = ST_ALUWB;
      ST_LUI:      state_d = ST_ALUWB;
      ST_JAL:      state_d = ST_ALUWB;
      ST_ALUWB:    state_d = ST_FETCH;
      ST_BEQ:      state_d = ST_FETCH;
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_HALT;
    endcase
    if (wd_expire) state_d = ST_HALT;
  end

  // Counter restarts on every state change, so each request state begins counting from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      wd_cnt_q  <= '0;
      illegal   <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (set_illegal) illegal <= 1'b1;
      if (wd_expire)   bus_err <= 1'b1;
      if (state_d != state_q) begin
        wd_cnt_q <= '0;
      end else if (wait_mem && (wd_cnt_q != 16'hFFFF)) begin
        wd_cnt_q <= wd_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    pc_update     = 1'b0;
    adr_src       = 1'b0;
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    branch        = 1'b0;
    instr_retired = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    case (state_q)
      ST_FETCH: begin
        mem_req    = 1'b1;
        ir_write   = mem_ready;
        pc_update  = mem_ready;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
      end
      ST_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      ST_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEMREAD: begin
        adr_src = 1'b1;
        mem_req = 1'b1;
      end
      ST_MEMWB: begin
        result_src    = RES_RDATA;
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      ST_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_req       = 1'b1;
        mem_write     = 1'b1;
        instr_retired = mem_ready;
      end
      ST_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      ST_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      ST_LUI: begin
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_LUI;
      end
      ST_ALUWB: begin
        reg_write     = 1'b1;
        instr_retired = 1'b1;
      end
      ST_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_update = 1'b1;
      end
      ST_BEQ: begin
        alu_src_a     = SRCA_RS1;
        alu_op        = ALUOP_SUB;
        branch        = 1'b1;
        instr_retired = 1'b1;
      end
      default: ;
    endcase
    // Reset silences every enable and select so an abandoned instruction has no side effects.
    if (rst) begin
      pc_update     = 1'b0;
      adr_src       = 1'b0;
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      branch        = 1'b0;
      instr_retired = 1'b0;
      result_src    = 2'b00;
      alu_src_a     = 2'b00;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
    end
  end

  assign pc_write = pc_update | (branch & zero);

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboarded bench for multi_cycle_controller: per-cycle expected output vectors vs. sampled outputs.
module tb_multi_cycle_controller;

  localparam int TMO = 4;
  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMREAD = 3, S_MEMWB = 4,
                 S_MEMWRITE = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BEQ = 9,
                 S_JAL = 10, S_LUI = 11, S_HALT = 12, S_RST = 13;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011,
                         BQ = 7'b1100011, JL = 7'b1101111, LU = 7'b0110111, BAD = 7'b1111111;

  logic clk = 1'b0;
  logic rst, zero, mem_ready;
  logic [6:0] op;
  logic pc_write, adr_src, mem_req, mem_write, ir_write, reg_write, branch, instr_retired;
  logic illegal, bus_err;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src;
  logic [20:0] outv;

  int checks = 0, passed = 0, ret_seen = 0;
  logic exp_ill = 1'b0, exp_berr = 1'b0;
  logic [20:0] exp_q[$];
  logic [20:0] obs_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  multi_cycle_controller #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .mem_req(mem_req), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .branch(branch),
    .instr_retired(instr_retired), .illegal(illegal), .bus_err(bus_err),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .imm_src(imm_src)
  );

  assign outv = {pc_write, adr_src, mem_req, mem_write, ir_write, reg_write, branch,
                 instr_retired, illegal, bus_err, result_src, alu_src_a, alu_src_b,
                 alu_op, imm_src};

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b1101111: return 3'b011;
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b0110111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic logic [20:0] expect_vec(input int st, input logic [6:0] o, input logic z,
                                             input logic mr, input logic ill, input logic be);
    logic pcw, adr, mrq, mw, irw, rw, br, ret;
    logic [1:0] rs, a, b, aop;
    {pcw, adr, mrq, mw, irw, rw, br, ret} = 8'h00;
    {rs, a, b, aop} = 8'h00;
    case (st)
      S_FETCH:    begin mrq = 1; irw = mr; pcw = mr; b = 2'b10; rs = 2'b10; end
      S_DECODE:   begin a = 2'b01; b = 2'b01; end
      S_MEMADR:   begin a = 2'b10; b = 2'b01; end
      S_MEMREAD:  begin adr = 1; mrq = 1; end
      S_MEMWB:    begin rs = 2'b01; rw = 1; ret = 1; end
      S_MEMWRITE: begin adr = 1; mrq = 1; mw = 1; ret = mr; end
      S_EXECR:    begin a = 2'b10; aop = 2'b10; end
      S_EXECI:    begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      S_LUI:      begin b = 2'b01; aop = 2'b11; end
      S_ALUWB:    begin rw = 1; ret = 1; end
      S_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1; end
      S_BEQ:      begin a = 2'b10; aop = 2'b01; br = 1; ret = 1; pcw = z; end
      default:    ;
    endcase
    return {pcw, adr, mrq, mw, irw, rw, br, ret, ill, be, rs, a, b, aop, imm_of(o)};
  endfunction

  // Push the expectation for the cycle being driven, capture the DUT at mid-cycle, advance.
  task automatic step(input int st, input string tag);
    exp_q.push_back(expect_vec(st, op, zero, mem_ready, exp_ill, exp_berr));
    tag_q.push_back(tag);
    @(negedge clk);
    obs_q.push_back(outv);
    if (instr_retired === 1'b1) ret_seen++;
    @(posedge clk);
    #1;
    if (st == S_RST) begin exp_ill = 1'b0; exp_berr = 1'b0; end
  endtask

  task automatic rnd_mr();
    mem_ready = 1'($urandom_range(1));
  endtask

  task automatic run_instr(input logic [6:0] o, input logic z, input int fw, input int mw);
    op = o; zero = z;
    for (int i = 0; i < fw; i++) begin mem_ready = 0; step(S_FETCH, "fetch_wait"); end
    mem_ready = 1; step(S_FETCH, "fetch");
    rnd_mr(); step(S_DECODE, "decode");
    case (o)
      LW: begin
        rnd_mr(); step(S_MEMADR, "memadr");
        for (int i = 0; i < mw; i++) begin mem_ready = 0; step(S_MEMREAD, "memread_wait"); end
        mem_ready = 1; step(S_MEMREAD, "memread");
        rnd_mr(); step(S_MEMWB, "memwb");
      end
      SW: begin
        rnd_mr(); step(S_MEMADR, "memadr");
        for (int i = 0; i < mw; i++) begin mem_ready = 0; step(S_MEMWRITE, "memwrite_wait"); end
        mem_ready = 1; step(S_MEMWRITE, "memwrite");
      end
      RT: begin rnd_mr(); step(S_EXECR, "execr"); rnd_mr(); step(S_ALUWB, "aluwb"); end
      IT: begin rnd_mr(); step(S_EXECI, "execi"); rnd_mr(); step(S_ALUWB, "aluwb"); end
      LU: begin rnd_mr(); step(S_LUI, "lui"); rnd_mr(); step(S_ALUWB, "aluwb"); end
      JL: begin rnd_mr(); step(S_JAL, "jal"); rnd_mr(); step(S_ALUWB, "aluwb"); end
      BQ: begin rnd_mr(); step(S_BEQ, "beq"); end
      default: begin exp_ill = 1'b1; rnd_mr(); step(S_HALT, "halt"); end
    endcase
  endtask

  task automatic test_reset();
    logic [20:0] e, o; string t;
    rst = 1; op = RT; zero = 1; mem_ready = 1;
    step(S_RST, "rst0");
    op = JL; step(S_RST, "rst1_imm");
    rst = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL reset/%s: got %b want %b", t, o, e); else passed++;
    end
  endtask

  task automatic test_load();
    logic [20:0] e, o; string t;
    ret_seen = 0;
    run_instr(LW, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL load/%s: got %b want %b", t, o, e); else passed++;
    end
    checks++;
    if (ret_seen !== 1) $display("FAIL load_retire_count: got %0d want 1", ret_seen); else passed++;
  endtask

  task automatic test_store();
    logic [20:0] e, o; string t;
    ret_seen = 0;
    run_instr(SW, 0, 2, 3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL store/%s: got %b want %b", t, o, e); else passed++;
    end
    checks++;
    if (ret_seen !== 1) $display("FAIL store_retire_count: got %0d want 1", ret_seen); else passed++;
  endtask

  task automatic test_alu();
    logic [20:0] e, o; string t;
    ret_seen = 0;
    run_instr(RT, 0, 1, 0);
    run_instr(IT, 1, 0, 0);
    run_instr(LU, 0, 0, 0);
    run_instr(JL, 1, 2, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL alu/%s: got %b want %b", t, o, e); else passed++;
    end
    checks++;
    if (ret_seen !== 4) $display("FAIL alu_retire_count: got %0d want 4", ret_seen); else passed++;
  endtask

  task automatic test_branch();
    logic [20:0] e, o; string t;
    ret_seen = 0;
    run_instr(BQ, 1, 0, 0);
    run_instr(BQ, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL branch/%s: got %b want %b", t, o, e); else passed++;
    end
    checks++;
    if (ret_seen !== 2) $display("FAIL branch_retire_count: got %0d want 2", ret_seen); else passed++;
  endtask

  task automatic test_illegal();
    logic [20:0] e, o; string t;
    run_instr(BAD, 0, 0, 0);
    for (int i = 0; i < 19; i++) begin
      rnd_mr(); zero = 1'($urandom_range(1)); step(S_HALT, "halt_hold");
    end
    checks++;
    if (illegal !== 1'b1) $display("FAIL illegal_sticky: got %b want 1", illegal); else passed++;
    rst = 1; step(S_RST, "illegal_rst"); rst = 0;
    checks++;
    if (illegal !== 1'b0) $display("FAIL illegal_cleared: got %b want 0", illegal); else passed++;
    run_instr(RT, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL illegal/%s: got %b want %b", t, o, e); else passed++;
    end
  endtask

  task automatic test_timeout();
    logic [20:0] e, o; string t;
    op = LW; zero = 0;
    for (int i = 0; i < TMO; i++) begin mem_ready = 0; step(S_FETCH, "fetch_starve"); end
    exp_berr = 1'b1;
    for (int i = 0; i < 3; i++) begin rnd_mr(); step(S_HALT, "halt_buserr"); end
    checks++;
    if (bus_err !== 1'b1) $display("FAIL bus_err_fetch: got %b want 1", bus_err); else passed++;
    rst = 1; step(S_RST, "timeout_rst"); rst = 0;
    run_instr(LW, 0, TMO - 1, 0);
    checks++;
    if (bus_err !== 1'b0) $display("FAIL ready_wins: got bus_err %b want 0", bus_err); else passed++;
    op = LW;
    for (int i = 0; i < 2; i++) begin mem_ready = 0; step(S_FETCH, "fetch_wait"); end
    mem_ready = 1; step(S_FETCH, "fetch");
    rnd_mr(); step(S_DECODE, "decode");
    rnd_mr(); step(S_MEMADR, "memadr");
    for (int i = 0; i < TMO; i++) begin mem_ready = 0; step(S_MEMREAD, "memread_starve"); end
    exp_berr = 1'b1;
    rnd_mr(); step(S_HALT, "halt_buserr_rd");
    checks++;
    if (bus_err !== 1'b1) $display("FAIL bus_err_memread: got %b want 1", bus_err); else passed++;
    rst = 1; step(S_RST, "timeout_rst2"); rst = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL timeout/%s: got %b want %b", t, o, e); else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [20:0] e, o; string t;
    ret_seen = 0;
    op = LW; zero = 0;
    mem_ready = 1; step(S_FETCH, "fetch");
    step(S_DECODE, "decode");
    step(S_MEMADR, "memadr");
    mem_ready = 0; step(S_MEMREAD, "memread_wait");
    rst = 1; mem_ready = 1; step(S_RST, "rst_in_memread"); rst = 0;
    op = SW;
    mem_ready = 1; step(S_FETCH, "fetch");
    step(S_DECODE, "decode");
    step(S_MEMADR, "memadr");
    mem_ready = 0; step(S_MEMWRITE, "memwrite_wait");
    rst = 1; mem_ready = 1; step(S_RST, "rst_in_memwrite"); rst = 0;
    checks++;
    if (ret_seen !== 0) $display("FAIL abandoned_retire: got %0d want 0", ret_seen); else passed++;
    run_instr(IT, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL reset_mid/%s: got %b want %b", t, o, e); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] e, o; string t;
    logic [6:0] ops [7];
    ops = '{LW, SW, RT, IT, BQ, JL, LU};
    ret_seen = 0;
    for (int n = 0; n < 12; n++) begin
      run_instr(ops[$urandom_range(6)], 1'($urandom_range(1)),
                int'($urandom_range(2)), int'($urandom_range(3)));
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if (o !== e) $display("FAIL b2b/%s: got %b want %b", t, o, e); else passed++;
    end
    checks++;
    if (ret_seen !== 12) $display("FAIL b2b_retire_count: got %0d want 12", ret_seen); else passed++;
  endtask

  initial begin
    rst = 1; op = '0; zero = 0; mem_ready = 0;
    test_reset();
    test_load();
    test_store();
    test_alu();
    test_branch();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
